// File: rtl/ro_event_decoder.sv
// Readout-bus event decoder: tracks the gray-tree slot schedule and queues timestamped event words.
// Latency: 1 cycle from the sampling edge to head visibility on an empty FIFO.
// Backpressure: valid/ready on the head; a push into a full FIFO without a pop is dropped and counted.

module ro_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    input  logic [W-1:0]               in_dat,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [W-1:0]               out_dat,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign out_vld = (level != '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = out_vld & out_rdy;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = in_vld & (~full | do_pop);
    assign drop    = in_vld & full & ~do_pop;
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

module ro_event_decoder #(
    parameter int N_CH       = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16
) (
    input  logic                          clk_master,
    input  logic                          rstb,
    input  logic                          en,
    input  logic [1:0]                    read_out_I,
    input  logic [1:0]                    read_out_Q,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [3:0]                    evt_ch,
    output logic [3:0]                    evt_bits,
    output logic [TS_W-1:0]               evt_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt
);
    typedef struct packed {
        logic [3:0]      ch;
        logic [3:0]      bits;
        logic [TS_W-1:0] ts;
    } evt_t;

    logic [N_CH-1:0] cnt;
    logic [TS_W-1:0] ts;
    logic [3:0]      slot_ch;
    logic            slot_idle;
    logic            cap_vld;
    evt_t            cap_dat;
    evt_t            head_dat;
    logic            drop;

    // Slot owner is the bit that toggles on the gray step cnt -> cnt+1.
    always_comb begin
        logic run;
        slot_ch = '0;
        run     = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (run && cnt[i]) begin
                slot_ch = slot_ch + 4'd1;
            end else begin
                run = 1'b0;
            end
        end
    end

    assign slot_idle = &cnt;

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
            ts  <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (en) begin
                cnt <= cnt + N_CH'(1);
            end
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cap_vld <= 1'b0;
            cap_dat <= '0;
        end else begin
            cap_vld <= en & ~slot_idle & (read_out_I[0] | read_out_Q[0]);
            if (en && !slot_idle) begin
                cap_dat.ch   <= slot_ch;
                cap_dat.ts   <= ts;
                cap_dat.bits <= {read_out_Q[1] & read_out_Q[0], read_out_Q[0],
                                 read_out_I[1] & read_out_I[0], read_out_I[0]};
            end
        end
    end

    ro_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(evt_t))
    ) u_fifo (
        .clk     (clk_master),
        .rst_n   (rstb),
        .in_vld  (cap_vld),
        .in_dat  (cap_dat),
        .out_vld (evt_valid),
        .out_rdy (evt_ready),
        .out_dat (head_dat),
        .level   (fifo_level),
        .drop    (drop)
    );

    // Storage is not reset, so the head fields are forced to zero while empty.
    assign evt_ch   = evt_valid ? head_dat.ch   : '0;
    assign evt_bits = evt_valid ? head_dat.bits : '0;
    assign evt_ts   = evt_valid ? head_dat.ts   : '0;

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_ro_event_decoder.sv
// Directed bench for ro_event_decoder: slot attribution, masking, overflow, full-FIFO pop/push and async reset.
module tb_ro_event_decoder;
    logic        clk_master = 1'b0;
    logic        rstb = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  read_out_I = 2'b00;
    logic [1:0]  read_out_Q = 2'b00;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [3:0]  evt_ch;
    logic [3:0]  evt_bits;
    logic [15:0] evt_ts;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    // Owner channel of slots 0..9 (trailing ones of the slot count), worked by hand.
    localparam logic [3:0] CH_TAB [10] = '{4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd1, 4'd0, 4'd3, 4'd0, 4'd1};

    ro_event_decoder dut (
        .clk_master (clk_master),
        .rstb       (rstb),
        .en         (en),
        .read_out_I (read_out_I),
        .read_out_Q (read_out_Q),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ch     (evt_ch),
        .evt_bits   (evt_bits),
        .evt_ts     (evt_ts),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk_master = ~clk_master;

    task automatic tick(input logic [1:0] i, input logic [1:0] q);
        read_out_I = i;
        read_out_Q = q;
        @(posedge clk_master);
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        en = 1'b0;
        evt_ready = 1'b0;
        read_out_I = 2'b00;
        read_out_Q = 2'b00;
        repeat (2) @(posedge clk_master);
        @(negedge clk_master);
        rstb = 1'b1;
        en = 1'b1;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (2) @(posedge clk_master);
        #1;
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if ({evt_ch, evt_bits, evt_ts} !== 24'd0) begin failures++; $display("FAIL reset_head got=%h exp=0", {evt_ch, evt_bits, evt_ts}); end
        checks++; if ({overflow, drop_cnt} !== 9'd0) begin failures++; $display("FAIL reset_ovf got=%h exp=0", {overflow, drop_cnt}); end
    endtask

    task automatic test_single_event();
        do_reset();
        repeat (3) tick(2'b00, 2'b00);
        tick(2'b01, 2'b00);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", evt_valid); end
        tick(2'b00, 2'b00);
        checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", evt_valid); end
        checks++; if (evt_ch !== 4'd2) begin failures++; $display("FAIL single_ch got=%0d exp=2", evt_ch); end
        checks++; if (evt_bits !== 4'b0001) begin failures++; $display("FAIL single_bits got=%b exp=0001", evt_bits); end
        checks++; if (evt_ts !== 16'd3) begin failures++; $display("FAIL single_ts got=%0d exp=3", evt_ts); end
        repeat (2) tick(2'b00, 2'b00);
        checks++; if (fifo_level !== 4'd1 || evt_ts !== 16'd3) begin failures++; $display("FAIL single_stable got lvl=%0d ts=%0d exp lvl=1 ts=3", fifo_level, evt_ts); end
        evt_ready = 1'b1;
        tick(2'b00, 2'b00);
        evt_ready = 1'b0;
        checks++; if (fifo_level !== 4'd0 || evt_valid !== 1'b0) begin failures++; $display("FAIL single_pop got lvl=%0d vld=%b exp 0/0", fifo_level, evt_valid); end
    endtask

    task automatic test_pol_mask();
        do_reset();
        tick(2'b11, 2'b01);
        tick(2'b10, 2'b00);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        checks++; if (fifo_level !== 4'd1) begin failures++; $display("FAIL mask_level got=%0d exp=1", fifo_level); end
        checks++; if (evt_ch !== 4'd0 || evt_bits !== 4'b0111 || evt_ts !== 16'd0) begin failures++; $display("FAIL mask_word got ch=%0d bits=%b ts=%0d exp ch=0 bits=0111 ts=0", evt_ch, evt_bits, evt_ts); end
    endtask

    task automatic test_enable();
        do_reset();
        repeat (3) tick(2'b00, 2'b00);
        en = 1'b0;
        repeat (3) tick(2'b01, 2'b00);
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL en_low_level got=%0d exp=0", fifo_level); end
        en = 1'b1;
        tick(2'b01, 2'b00);
        en = 1'b0;
        tick(2'b00, 2'b00);
        checks++; if (fifo_level !== 4'd1 || evt_ch !== 4'd2 || evt_ts !== 16'd6) begin failures++; $display("FAIL en_resume got lvl=%0d ch=%0d ts=%0d exp lvl=1 ch=2 ts=6", fifo_level, evt_ch, evt_ts); end
        en = 1'b1;
    endtask

    task automatic test_idle_wrap();
        do_reset();
        evt_ready = 1'b0;
        repeat (1023) tick(2'b00, 2'b00);
        tick(2'b11, 2'b11);
        tick(2'b11, 2'b11);
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL idle_slot got lvl=%0d exp=0", fifo_level); end
        tick(2'b00, 2'b00);
        checks++; if (fifo_level !== 4'd1) begin failures++; $display("FAIL wrap_level got=%0d exp=1", fifo_level); end
        checks++; if (evt_ch !== 4'd0 || evt_ts !== 16'd1024 || evt_bits !== 4'b1111) begin failures++; $display("FAIL wrap_word got ch=%0d ts=%0d bits=%b exp ch=0 ts=1024 bits=1111", evt_ch, evt_ts, evt_bits); end
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (10) tick(2'b01, 2'b00);
        tick(2'b00, 2'b00);
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
        checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_drop got ovf=%b drop=%0d exp ovf=1 drop=2", overflow, drop_cnt); end
        evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_ch !== CH_TAB[k] || evt_ts !== 16'(k) || evt_bits !== 4'b0001) begin
                failures++;
                $display("FAIL ovf_drain%0d got vld=%b ch=%0d ts=%0d bits=%b exp vld=1 ch=%0d ts=%0d bits=0001",
                         k, evt_valid, evt_ch, evt_ts, evt_bits, CH_TAB[k], k);
            end
            tick(2'b00, 2'b00);
        end
        evt_ready = 1'b0;
        checks++; if (fifo_level !== 4'd0 || evt_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got lvl=%0d vld=%b exp 0/0", fifo_level, evt_valid); end
        checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_sticky got ovf=%b drop=%0d exp ovf=1 drop=2", overflow, drop_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (8) tick(2'b01, 2'b00);
        tick(2'b01, 2'b00);
        checks++; if (fifo_level !== 4'd8 || evt_ts !== 16'd0) begin failures++; $display("FAIL b2b_full got lvl=%0d ts=%0d exp lvl=8 ts=0", fifo_level, evt_ts); end
        evt_ready = 1'b1;
        tick(2'b00, 2'b00);
        checks++; if (fifo_level !== 4'd8 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin failures++; $display("FAIL b2b_pushpop got lvl=%0d drop=%0d ovf=%b exp lvl=8 drop=0 ovf=0", fifo_level, drop_cnt, overflow); end
        for (int k = 1; k < 9; k++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_ch !== CH_TAB[k] || evt_ts !== 16'(k)) begin
                failures++;
                $display("FAIL b2b_order%0d got vld=%b ch=%0d ts=%0d exp vld=1 ch=%0d ts=%0d", k, evt_valid, evt_ch, evt_ts, CH_TAB[k], k);
            end
            tick(2'b00, 2'b00);
        end
        evt_ready = 1'b0;
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (10) tick(2'b01, 2'b00);
        tick(2'b00, 2'b00);
        evt_ready = 1'b1;
        repeat (3) tick(2'b00, 2'b00);
        evt_ready = 1'b0;
        checks++; if (fifo_level !== 4'd5 || overflow !== 1'b1) begin failures++; $display("FAIL areset_pre got lvl=%0d ovf=%b exp lvl=5 ovf=1", fifo_level, overflow); end
        #2;
        rstb = 1'b0;
        #1;
        checks++; if (evt_valid !== 1'b0 || fifo_level !== 4'd0) begin failures++; $display("FAIL areset_fifo got vld=%b lvl=%0d exp 0/0", evt_valid, fifo_level); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL areset_ovf got ovf=%b drop=%0d exp 0/0", overflow, drop_cnt); end
        checks++; if ({evt_ch, evt_bits, evt_ts} !== 24'd0) begin failures++; $display("FAIL areset_head got=%h exp=0", {evt_ch, evt_bits, evt_ts}); end
        @(negedge clk_master);
        rstb = 1'b1;
        en = 1'b1;
        repeat (3) tick(2'b00, 2'b00);
        tick(2'b01, 2'b00);
        tick(2'b00, 2'b00);
        checks++; if (fifo_level !== 4'd1 || evt_ch !== 4'd2 || evt_ts !== 16'd3) begin failures++; $display("FAIL areset_restart got lvl=%0d ch=%0d ts=%0d exp lvl=1 ch=2 ts=3", fifo_level, evt_ch, evt_ts); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_pol_mask();
        test_enable();
        test_idle_wrap();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ro_event_decoder.md
Name: ro_event_decoder

Overview:
- Receive-side decoder for the shared, time-multiplexed readout bus (read_out_I/read_out_Q) driven by the chain of cochlea channel cells.
- Each clk_master cycle, exactly one channel owns the bus, selected by the gray-clock-tree schedule. The decoder tracks that schedule and attributes the sampled event/polarity bits to a channel index.
- It emits timestamped event words through a FIFO with a valid/ready handshake. It sits off-array, between the pad/bus capture and the host interface logic.

Parameters:
- N_CH, 10, number of scheduled channel slots (gray tree depth); slot counter width.
- FIFO_DEPTH, 8, event FIFO entries (power of 2, ≥2).
- TS_W, 16, timestamp counter width.

Ports:
- clk_master  in  1  master clock, same clock as the array; all state on posedge.
- rstb  in  1  asynchronous active-low reset.
- en  in  1  decode enable; when low the slot counter holds and nothing is sampled.
- read_out_I  in  2  [0]=event, [1]=polarity×event, I path of the slot owner.
- read_out_Q  in  2  [0]=event, [1]=polarity×event, Q path of the slot owner.
- evt_valid  out  1  FIFO head holds a valid word.
- evt_ready  in  1  consumer accepts the head word when evt_valid & evt_ready at posedge.
- evt_ch  out  4  channel index of the head word.
- evt_bits  out  4  {Q_pol, Q_eve, I_pol, I_eve} of the head word.
- evt_ts  out  TS_W  timestamp of the head word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one event was dropped.
- drop_cnt  out  8  dropped-event count, saturating.

Behaviour:
- Reset (rstb=0, asynchronous): slot counter=0, ts=0, FIFO empty, capture register cleared; evt_valid=0, evt_ch=0, evt_bits=0, evt_ts=0, fifo_level=0, overflow=0, drop_cnt=0. Reset asserted mid-operation discards all queued words immediately.
- Slot counter cnt:
  - N_CH bits; increments every posedge when en=1 and wraps 2^N_CH−1 → 0. Holds when en=0.
  - Reset release must coincide with array reset release so that cnt=0 aligns with the array's first slot.
- Slot owner for the cycle in which cnt=c:
  - ch = number of trailing ones of c (the bit that toggles in the gray count c→c+1).
  - ch ranges 0..N_CH−1. If c = all-ones (trailing ones = N_CH), the slot is idle and no event is ever generated, whatever the inputs.
- Timestamp ts: free-running TS_W-bit counter, increments every posedge regardless of en, wraps to 0.
- Capture, stage 1:
  - At posedge t with en=1 and a non-idle slot, register ch, ts, and the masked bits:
    - I_pol = read_out_I[1] & read_out_I[0]
    - Q_pol = read_out_Q[1] & read_out_Q[0]
  - A capture is marked valid only if read_out_I[0] | read_out_Q[0].
  - Polarity without an event is masked to 0 and never on its own generates a word.
- Push, stage 2: a valid capture is written to the FIFO at posedge t+1. evt_valid is visible after posedge t+1. Total latency is 1 cycle, from the sampling edge to head availability on an empty FIFO.
- Handshake:
  - evt_valid/evt_ch/evt_bits/evt_ts reflect the FIFO head and stay stable while evt_valid=1 and evt_ready=0.
  - A pop occurs at a posedge with evt_valid & evt_ready. evt_ready while empty has no effect.
- Full FIFO:
  - A push with no simultaneous pop drops the word: overflow←1 (sticky until reset), drop_cnt increments, saturating at 255.
  - A push with a simultaneous pop while full is accepted; level is unchanged.
- Empty FIFO: a simultaneous push and pop is not possible; the pop is ignored and the push is accepted.
- fifo_level is exact every cycle; pointers wrap modulo FIFO_DEPTH.
- en falling: an already-captured word is still pushed. en rising resumes from the held cnt.

Test Plan:
- Reset, en=1, read_out_I=2'b01 only while cnt=3 → one word with evt_ch=2, evt_bits=4'b0001, evt_ts=3, evt_valid rising after the edge following sampling.
- I=2'b11 and Q=2'b01 at cnt=0, then I=2'b10 alone at cnt=1 → one word only: ch=0, bits=4'b0111. The pol-only input at cnt=1 generates nothing.
- Inputs 2'b11 held on both paths through cnt=1023 → no word for the idle slot. Word for cnt=1024 (wrapped to 0) has ch=0, ts=1024.
- evt_ready=0, events in 10 consecutive non-idle slots, FIFO_DEPTH=8 → fifo_level=8, overflow=1, drop_cnt=2. Draining with ready=1 returns the first 8 words in order.
- FIFO full with ready=1 and an event in the same cycle → level stays 8, drop_cnt unchanged, popped/pushed order preserved.
- rstb pulsed low asynchronously while the FIFO holds 5 words → evt_valid=0, level=0, overflow=0, drop_cnt=0, cnt=ts=0 immediately, without waiting for a clock edge.
